// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester port of the dmem arbiter. The CPU load/store port and the
// debug/loader port share this shape, so the arbiter takes two of them.
//
// Signals
//   req          requester -> arbiter  request; fields held stable until gnt
//   we           requester -> arbiter  store(1) / load(0)
//   size         requester -> arbiter  00 byte, 01 half, 10 word, 11 reserved
//   is_unsigned  requester -> arbiter  load zero-extend(1) / sign-extend(0)
//   addr         requester -> arbiter  byte address
//   wdata        requester -> arbiter  store data, right-justified
//   gnt          arbiter -> requester  combinational accept for this cycle
//   rvalid       arbiter -> requester  response valid, one cycle after gnt
//   rdata        arbiter -> requester  extended load data (0 for stores/errors)
//   err          arbiter -> requester  with rvalid: misaligned or reserved size
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, is_unsigned, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, is_unsigned, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the four byte-lane dmem banks between the CPU load/store port (c)
// and the debug/loader port (d). At most one requester is granted per cycle;
// the granted request is turned into per-lane write enables and replicated
// write data, and loads are extracted/extended into a registered response.
//
// Parameters
//   MAX_WAIT      consecutive denied cycles of port d before it is forced to win
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   c, d          requester ports (dmem_arbiter_if.slave)
//   dmem_addr     address to all four banks (0 when nothing is granted)
//   dmem_we       per-lane write enable, bit n -> bank byte_num n
//   dmem_wr_data  lane-aligned write data, lane n = bits [8n+7:8n]
//   dmem_rd_data  concatenated combinational bank read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        c,
    dmem_arbiter_if.slave        d,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_we,
    output logic [31:0]          dmem_wr_data,
    input  logic [31:0]          dmem_rd_data
);

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    // Misaligned half/word accesses and the reserved size are errors.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   align_err = 1'b0;
            2'b01:   align_err = lo[0];
            2'b10:   align_err = (lo != 2'b00);
            default: align_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << lo;
            2'b01:   lane_mask = 4'b0011 << lo;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicating the data lets the lane enables alone pick the target bytes.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   replicate = {4{wdata[7:0]}};
            2'b01:   replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {lo, 3'b000};
        case (size)
            2'b00:   load_extract = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extract = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extract = rd;
        endcase
    endfunction

    logic [3:0]  wait_cnt_r;
    logic        c_gnt_s;
    logic        d_gnt_s;
    logic        any_gnt_s;
    logic        sel_we_s;
    logic [1:0]  sel_size_s;
    logic        sel_uns_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        err_s;
    logic [31:0] load_data_s;

    logic        c_rvalid_r;
    logic [31:0] c_rdata_r;
    logic        c_err_r;
    logic        d_rvalid_r;
    logic [31:0] d_rdata_r;
    logic        d_err_r;

    // Arbitration: c has priority unless d has waited MAX_WAIT cycles; no grants in reset.
    always_comb begin
        c_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (rst) begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (c.req && d.req) begin
            if (wait_cnt_r == MAX_WAIT_L) begin
                d_gnt_s = 1'b1;
            end else begin
                c_gnt_s = 1'b1;
            end
        end else if (c.req) begin
            c_gnt_s = 1'b1;
        end else if (d.req) begin
            d_gnt_s = 1'b1;
        end else begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Request mux and datapath for whichever port won this cycle.
    always_comb begin
        any_gnt_s   = c_gnt_s | d_gnt_s;
        sel_we_s    = 1'b0;
        sel_size_s  = 2'b00;
        sel_uns_s   = 1'b0;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        if (c_gnt_s) begin
            sel_we_s    = c.we;
            sel_size_s  = c.size;
            sel_uns_s   = c.is_unsigned;
            sel_addr_s  = c.addr;
            sel_wdata_s = c.wdata;
        end else if (d_gnt_s) begin
            sel_we_s    = d.we;
            sel_size_s  = d.size;
            sel_uns_s   = d.is_unsigned;
            sel_addr_s  = d.addr;
            sel_wdata_s = d.wdata;
        end else begin
            sel_we_s    = 1'b0;
        end

        err_s        = any_gnt_s & align_err(sel_size_s, sel_addr_s[1:0]);
        dmem_addr    = sel_addr_s;
        dmem_wr_data = any_gnt_s ? replicate(sel_size_s, sel_wdata_s) : 32'h0000_0000;

        // An erroring store must never touch memory.
        if (any_gnt_s && sel_we_s && !err_s) begin
            dmem_we = lane_mask(sel_size_s, sel_addr_s[1:0]);
        end else begin
            dmem_we = 4'b0000;
        end

        if (any_gnt_s && !sel_we_s && !err_s) begin
            load_data_s = load_extract(sel_size_s, sel_uns_s, sel_addr_s[1:0], dmem_rd_data);
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    // Starvation counter for port d: counts denied cycles, saturates at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (!d.req || d_gnt_s) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r != MAX_WAIT_L) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end
    end

    // Port c response register; rdata/err hold when c is not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_rvalid_r <= 1'b0;
            c_rdata_r  <= 32'h0000_0000;
            c_err_r    <= 1'b0;
        end else begin
            c_rvalid_r <= c_gnt_s;
            if (c_gnt_s) begin
                c_rdata_r <= load_data_s;
                c_err_r   <= err_s;
            end
        end
    end

    // Port d response register; rdata/err hold when d is not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_rvalid_r <= 1'b0;
            d_rdata_r  <= 32'h0000_0000;
            d_err_r    <= 1'b0;
        end else begin
            d_rvalid_r <= d_gnt_s;
            if (d_gnt_s) begin
                d_rdata_r <= load_data_s;
                d_err_r   <= err_s;
            end
        end
    end

    assign c.gnt    = c_gnt_s;
    assign c.rvalid = c_rvalid_r;
    assign c.rdata  = c_rdata_r;
    assign c.err    = c_err_r;
    assign d.gnt    = d_gnt_s;
    assign d.rvalid = d_rvalid_r;
    assign d.rdata  = d_rdata_r;
    assign d.err    = d_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Table of single-cycle transactions with hand-computed results, followed by
// hand-written sequences for sustained contention and reset mid-operation.
// A small byte-lane memory model stands in for the four dmem banks.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        c;
        req_t        d;
        logic        e_cg;
        logic        e_dg;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_cv;
        logic [31:0] e_crd;
        logic        e_ce;
        logic        e_dv;
        logic [31:0] e_drd;
        logic        e_de;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;

    dmem_arbiter_if c_if ();
    dmem_arbiter_if d_if ();

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .c            (c_if),
        .d            (d_if),
        .dmem_addr    (dmem_addr),
        .dmem_we      (dmem_we),
        .dmem_wr_data (dmem_wr_data),
        .dmem_rd_data (dmem_rd_data)
    );

    // Four byte banks, combinational read, write at the clock edge.
    logic [7:0] bank [4][256] = '{default: '0};

    assign dmem_rd_data = {bank[3][dmem_addr[9:2]], bank[2][dmem_addr[9:2]],
                           bank[1][dmem_addr[9:2]], bank[0][dmem_addr[9:2]]};

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (dmem_we[n]) bank[n][dmem_addr[9:2]] <= dmem_wr_data[8*n +: 8];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic req_t rq(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.req = 1'b1; r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t nrq();
        req_t r;
        r.req = 1'b0; r.we = 1'b0; r.size = 2'b00; r.uns = 1'b0; r.addr = 32'h0; r.wdata = 32'h0;
        return r;
    endfunction

    task automatic drive(input req_t cv, input req_t dv);
        c_if.req = cv.req; c_if.we = cv.we; c_if.size = cv.size;
        c_if.is_unsigned = cv.uns; c_if.addr = cv.addr; c_if.wdata = cv.wdata;
        d_if.req = dv.req; d_if.we = dv.we; d_if.size = dv.size;
        d_if.is_unsigned = dv.uns; d_if.addr = dv.addr; d_if.wdata = dv.wdata;
    endtask

    vec_t vec [19];

    initial begin
        //          c request                          d request                           cg    dg    we       addr        wdata          cv    crdata        ce    dv    drdata        de
        vec[0]  = '{rq(1, SW, 0, 32'h10, 32'hDEADBEEF), nrq(), 1'b1, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[1]  = '{rq(0, SW, 0, 32'h10, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[2]  = '{rq(1, SB, 0, 32'h13, 32'h00000080), nrq(), 1'b1, 1'b0, 4'b1000, 32'h13, 32'h80808080, 1'b1, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[3]  = '{rq(0, SB, 0, 32'h13, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h13, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[4]  = '{rq(0, SB, 1, 32'h13, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h13, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[5]  = '{rq(0, SH, 0, 32'h12, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h12, 32'h0,        1'b1, 32'hFFFF80AD, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[6]  = '{rq(1, SH, 0, 32'h11, 32'h00001234), nrq(), 1'b1, 1'b0, 4'b0000, 32'h11, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vec[7]  = '{rq(0, SW, 0, 32'h22, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h22, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vec[8]  = '{rq(0, SW, 0, 32'h10, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0,        1'b1, 32'h80ADBEEF, 1'b0, 1'b0, 32'h00000000, 1'b0};
        vec[9]  = '{rq(0, SR, 0, 32'h10, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h10, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0};
        vec[10] = '{nrq(), rq(1, SW, 0, 32'h0, 32'h12345678), 1'b0, 1'b1, 4'b1111, 32'h0,  32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b0};
        vec[11] = '{nrq(), rq(0, SH, 1, 32'h2, 32'h0),        1'b0, 1'b1, 4'b0000, 32'h2,  32'h0,        1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00001234, 1'b0};
        vec[12] = '{nrq(), rq(0, SB, 0, 32'h0, 32'h0),        1'b0, 1'b1, 4'b0000, 32'h0,  32'h0,        1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00000078, 1'b0};
        vec[13] = '{nrq(), nrq(),                              1'b0, 1'b0, 4'b0000, 32'h0,  32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000078, 1'b0};
        vec[14] = '{rq(1, SH, 0, 32'h22, 32'hFFFF8001), nrq(), 1'b1, 1'b0, 4'b1100, 32'h22, 32'h80018001, 1'b1, 32'h00000000, 1'b0, 1'b0, 32'h00000078, 1'b0};
        vec[15] = '{rq(0, SH, 0, 32'h22, 32'h0),        nrq(), 1'b1, 1'b0, 4'b0000, 32'h22, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0, 32'h00000078, 1'b0};
        vec[16] = '{nrq(), rq(1, SB, 0, 32'h1, 32'h000000AB), 1'b0, 1'b1, 4'b0010, 32'h1,  32'hABABABAB, 1'b0, 32'hFFFF8001, 1'b0, 1'b1, 32'h00000000, 1'b0};
        vec[17] = '{nrq(), rq(0, SW, 0, 32'h0, 32'h0),        1'b0, 1'b1, 4'b0000, 32'h0,  32'h0,        1'b0, 32'hFFFF8001, 1'b0, 1'b1, 32'h1234AB78, 1'b0};
        vec[18] = '{nrq(), rq(1, SW, 0, 32'h2, 32'h55555555), 1'b0, 1'b1, 4'b0000, 32'h2,  32'h0,        1'b0, 32'hFFFF8001, 1'b0, 1'b1, 32'h00000000, 1'b1};

        // Reset state
        rst = 1'b1;
        drive(nrq(), nrq());
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst c_rvalid", 32'(c_if.rvalid), 32'h0);
        chk("rst c_rdata",  c_if.rdata,        32'h0);
        chk("rst c_err",    32'(c_if.err),     32'h0);
        chk("rst d_rvalid", 32'(d_if.rvalid), 32'h0);
        chk("rst d_rdata",  d_if.rdata,        32'h0);
        chk("rst dmem_we",  32'(dmem_we),      32'h0);
        chk("rst dmem_addr", dmem_addr,        32'h0);
        rst = 1'b0;

        // Table-driven single-cycle transactions
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vec[i].c, vec[i].d);
            #1;
            chk($sformatf("v%0d c_gnt", i),     32'(c_if.gnt), 32'(vec[i].e_cg));
            chk($sformatf("v%0d d_gnt", i),     32'(d_if.gnt), 32'(vec[i].e_dg));
            chk($sformatf("v%0d dmem_we", i),   32'(dmem_we),  32'(vec[i].e_we));
            chk($sformatf("v%0d dmem_addr", i), dmem_addr,     vec[i].e_addr);
            if (vec[i].e_we != 4'b0000) chk($sformatf("v%0d wr_data", i), dmem_wr_data, vec[i].e_wd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d c_rvalid", i), 32'(c_if.rvalid), 32'(vec[i].e_cv));
            chk($sformatf("v%0d c_rdata", i),  c_if.rdata,        vec[i].e_crd);
            chk($sformatf("v%0d c_err", i),    32'(c_if.err),    32'(vec[i].e_ce));
            chk($sformatf("v%0d d_rvalid", i), 32'(d_if.rvalid), 32'(vec[i].e_dv));
            chk($sformatf("v%0d d_rdata", i),  d_if.rdata,        vec[i].e_drd);
            chk($sformatf("v%0d d_err", i),    32'(d_if.err),    32'(vec[i].e_de));
        end

        // Sustained contention: C,C,C,C,D repeating, back-to-back responses
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
            @(negedge clk);
            drive(rq(0, SW, 0, 32'h10, 32'h0), rq(0, SW, 0, 32'h0, 32'h0));
            exp_d = ((k % 5) == 4);
            #1;
            chk($sformatf("arb%0d c_gnt", k), 32'(c_if.gnt), 32'(!exp_d));
            chk($sformatf("arb%0d d_gnt", k), 32'(d_if.gnt), 32'(exp_d));
            @(posedge clk);
            #1;
            chk($sformatf("arb%0d c_rvalid", k), 32'(c_if.rvalid), 32'(!exp_d));
            chk($sformatf("arb%0d d_rvalid", k), 32'(d_if.rvalid), 32'(exp_d));
            if (exp_d) chk($sformatf("arb%0d d_rdata", k), d_if.rdata, 32'h1234AB78);
            else       chk($sformatf("arb%0d c_rdata", k), c_if.rdata, 32'h80ADBEEF);
        end

        // Reset mid-operation: build up wait count and a pending C load, then reset
        @(negedge clk);
        drive(rq(0, SB, 1, 32'h13, 32'h0), rq(0, SW, 0, 32'h0, 32'h0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(nrq(), rq(1, SW, 0, 32'h0, 32'hCAFEF00D));
        #1;
        chk("rstop dmem_we", 32'(dmem_we),   32'h0);
        chk("rstop d_gnt",   32'(d_if.gnt),  32'h0);
        @(posedge clk);
        #1;
        chk("rstop c_rvalid", 32'(c_if.rvalid), 32'h0);
        chk("rstop c_rdata",  c_if.rdata,        32'h0);
        chk("rstop c_err",    32'(c_if.err),     32'h0);
        chk("rstop d_rvalid", 32'(d_if.rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // A cleared wait count means D waits the full four cycles again
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            drive(rq(0, SW, 0, 32'h10, 32'h0), rq(0, SW, 0, 32'h0, 32'h0));
            #1;
            chk($sformatf("post%0d d_gnt", k), 32'(d_if.gnt), 32'(k == 4));
            chk($sformatf("post%0d c_gnt", k), 32'(c_if.gnt), 32'(k != 4));
        end
        @(posedge clk);
        #1;
        chk("post mem intact", d_if.rdata, 32'h1234AB78);

        @(negedge clk);
        drive(nrq(), nrq());
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
